// File: rtl/weight_feeder.sv
`default_nettype none
// ============================================================================
// Module   : weight_feeder
// Purpose  : Steps through a K x N bank of signed weights and a latched +/-1
//            input vector, presenting one term per cycle to an external
//            accumulater as (magnitude, add/subtract, clear-first) and flagging
//            when each hidden unit's sum is valid at the accumulater output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous reset, active low
//   w_we       in   1          weight write strobe (ignored while busy)
//   w_addr     in   AW         weight index = k*N+i
//   w_data     in   WW         signed weight
//   x_in       in   K*N        input vector, bit k*N+i: 1 = +1, 0 = -1
//   start      in   1          begin one K*N-term evaluation (ignored while busy)
//   feed       out  13         |w| zero-extended
//   addflag    out  1          1 = add, 0 = subtract
//   setzero    out  1          first term of a unit
//   unit_done  out  1          accumulater output holds unit unit_idx's sum
//   unit_idx   out  KW         unit index, qualified by unit_done
//   busy       out  1          evaluation in progress
//   done       out  1          one-cycle pulse at end of evaluation
// ============================================================================
module weight_feeder #(
  parameter  int K  = 3,
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int AW = (K * N > 1) ? $clog2(K * N) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [WW-1:0]    w_data,
  input  logic [K*N-1:0]   x_in,
  input  logic             start,
  output logic [12:0]      feed,
  output logic             addflag,
  output logic             setzero,
  output logic             unit_done,
  output logic [KW-1:0]    unit_idx,
  output logic             busy,
  output logic             done
);

  localparam int KN = K * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] c_i_last   = IW'(N - 1);
  localparam logic [AW-1:0] c_idx_last = AW'(KN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [IW-1:0]    r_i;
  logic [AW-1:0]    r_idx;       // linear term index, always r_k*N + r_i
  logic             r_drain;     // second DRAIN cycle marker
  logic [KN-1:0]    r_x;
  logic [WW-1:0]    r_w [KN];

  logic [12:0]      r_feed;
  logic             r_addflag;
  logic             r_setzero;
  logic             r_last;      // a unit's last term was presented last cycle
  logic [KW-1:0]    r_last_k;
  logic             r_unit_done;
  logic [KW-1:0]    r_unit_idx;
  logic             r_done;

  // --------------------------------------------------------------------------
  // Next-term selection. Outputs are registered, so the term computed here is
  // the one that will be on the outputs during the following cycle.
  // --------------------------------------------------------------------------
  logic             w_last_term;
  logic [AW-1:0]    w_sel_idx;
  logic [WW-1:0]    w_sel_w;
  logic             w_sel_x;
  logic [WW:0]      w_ext;
  logic [WW:0]      w_mag;
  logic             w_term_add;

  assign w_last_term = (r_state == S_FEED) && (r_idx == c_idx_last);

  always_comb begin
    w_sel_idx = '0;
    if (r_state == S_FEED && !w_last_term) begin
      w_sel_idx = r_idx + 1'b1;
    end

    w_sel_w = r_w[w_sel_idx];
    w_sel_x = r_x[w_sel_idx];

    // On the start edge the first term comes straight from x_in, and a weight
    // written on that same edge to index 0 is forwarded so term (0,0) never
    // shows a stale value.
    if (r_state == S_IDLE) begin
      w_sel_x = x_in[0];
      if (w_we && w_addr == '0) begin
        w_sel_w = w_data;
      end
    end

    // One extra bit lets -2^(WW-1) produce its true magnitude 2^(WW-1).
    w_ext = {w_sel_w[WW-1], w_sel_w};
    w_mag = w_ext[WW] ? (~w_ext + 1'b1) : w_ext;

    // Product sign of w and x; a zero weight is forced to "add" so the
    // accumulater sees a harmless +0.
    if (w_sel_w == '0) begin
      w_term_add = 1'b1;
    end else begin
      w_term_add = ~(w_sel_w[WW-1] ^ ~w_sel_x);
    end
  end

  // --------------------------------------------------------------------------
  // Weight bank, FSM, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_i         <= '0;
      r_idx       <= '0;
      r_drain     <= 1'b0;
      r_x         <= '0;
      for (int j = 0; j < KN; j++) begin
        r_w[j] <= '0;
      end
      r_feed      <= '0;
      r_addflag   <= 1'b1;
      r_setzero   <= 1'b0;
      r_last      <= 1'b0;
      r_last_k    <= '0;
      r_unit_done <= 1'b0;
      r_unit_idx  <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_we && r_state == S_IDLE && w_addr <= c_idx_last) begin
        r_w[w_addr] <= w_data;
      end

      // Two-stage delay from "last term presented" to unit_done: one edge for
      // the accumulater to absorb the term, one for its output register.
      r_unit_done <= r_last;
      r_unit_idx  <= r_last_k;
      r_last      <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FEED;
            r_x       <= x_in;
            r_k       <= '0;
            r_i       <= '0;
            r_idx     <= '0;
            r_feed    <= 13'(w_mag);
            r_addflag <= w_term_add;
            r_setzero <= 1'b1;
          end
        end

        S_FEED: begin
          r_last   <= (r_i == c_i_last);
          r_last_k <= r_k;
          if (w_last_term) begin
            r_state   <= S_DRAIN;
            r_drain   <= 1'b0;
            r_feed    <= '0;
            r_addflag <= 1'b1;
            r_setzero <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_i == c_i_last) begin
              r_i <= '0;
              r_k <= r_k + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
            r_feed    <= 13'(w_mag);
            r_addflag <= w_term_add;
            r_setzero <= (r_i == c_i_last);
          end
        end

        S_DRAIN: begin
          if (!r_drain) begin
            r_drain <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign feed      = r_feed;
  assign addflag   = r_addflag;
  assign setzero   = r_setzero;
  assign unit_done = r_unit_done;
  assign unit_idx  = r_unit_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_feeder
// Purpose  : Self-checking bench for weight_feeder with a scoreboard of
//            expected terms/unit sums and a small accumulater model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_feeder;

  localparam int K  = 3;
  localparam int N  = 8;
  localparam int WW = 4;
  localparam int KN = K * N;
  localparam int AW = 5;
  localparam int KW = 2;

  logic            clk;
  logic            rst;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [WW-1:0]   w_data;
  logic [KN-1:0]   x_in;
  logic            start;
  logic [12:0]     feed;
  logic            addflag;
  logic            setzero;
  logic            unit_done;
  logic [KW-1:0]   unit_idx;
  logic            busy;
  logic            done;

  weight_feeder #(.K(K), .N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .x_in      (x_in),
    .start     (start),
    .feed      (feed),
    .addflag   (addflag),
    .setzero   (setzero),
    .unit_done (unit_done),
    .unit_idx  (unit_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int feed;
    bit add;
    bit sz;
  } term_t;

  typedef struct {
    int w;
    bit x;
    int feed;
    bit add;
  } vec_t;

  term_t q_term[$];
  int    q_sum[$];
  int    mw[KN];
  int    obs_feed[KN];
  bit    obs_add[KN];
  int    obs_sum[K];
  vec_t  tab[16];
  int    n_cmp = 0;
  int    n_err = 0;

  // Accumulater model: clears on setzero, one extra output register stage.
  int acc, acc_q;
  always @(posedge clk) begin
    if (!rst) begin
      acc   <= 0;
      acc_q <= 0;
    end else begin
      acc   <= (setzero ? 0 : acc) + (addflag ? int'(feed) : -int'(feed));
      acc_q <= acc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic write_w(input int a, input int v);
    logic [31:0] av;
    logic [31:0] vv;
    av = a;
    vv = v;
    w_we   = 1'b1;
    w_addr = av[AW-1:0];
    w_data = vv[WW-1:0];
    @(posedge clk); #1;
    w_we = 1'b0;
    mw[a] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " feed"},      int'(feed),      0);
    check({tag, " addflag"},   int'(addflag),   1);
    check({tag, " setzero"},   int'(setzero),   0);
    check({tag, " unit_done"}, int'(unit_done), 0);
    check({tag, " unit_idx"},  int'(unit_idx),  0);
    check({tag, " busy"},      int'(busy),      0);
    check({tag, " done"},      int'(done),      0);
  endtask

  // One full evaluation: pushes expectations, starts, checks every cycle.
  task automatic run_eval(input logic [KN-1:0] x, input bit disturb);
    term_t t;
    int    s;
    int    u;
    int    e_sum;
    bit    exp_ud;
    int    tv;
    logic [31:0] tvv;
    for (int k = 0; k < K; k++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        t.feed = (mw[k*N+i] < 0) ? -mw[k*N+i] : mw[k*N+i];
        t.add  = (mw[k*N+i] == 0) ? 1'b1 : ((mw[k*N+i] > 0) == x[k*N+i]);
        t.sz   = (i == 0);
        s += t.add ? t.feed : -t.feed;
        q_term.push_back(t);
      end
      q_sum.push_back(s);
    end
    start = 1'b1;
    x_in  = x;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = ~x;
    for (int cyc = 1; cyc <= KN + 2; cyc++) begin
      @(negedge clk);
      check($sformatf("busy c%0d", cyc), int'(busy), 1);
      if (cyc <= KN) begin
        obs_feed[cyc-1] = int'(feed);
        obs_add[cyc-1]  = addflag;
        if (q_term.size() == 0) begin
          check($sformatf("term queue c%0d", cyc), 0, 1);
        end else begin
          t = q_term.pop_front();
          check($sformatf("term{feed,add,sz} c%0d", cyc),
                int'(feed) * 4 + int'(addflag) * 2 + int'(setzero),
                t.feed * 4 + int'(t.add) * 2 + int'(t.sz));
        end
      end else begin
        check($sformatf("drain term c%0d", cyc),
              int'(feed) * 4 + int'(addflag) * 2 + int'(setzero), 2);
      end
      exp_ud = (cyc >= N + 2) && ((cyc - 2) % N == 0);
      check($sformatf("unit_done c%0d", cyc), int'(unit_done), int'(exp_ud));
      if (exp_ud) begin
        u = (cyc - 2) / N - 1;
        check($sformatf("unit_idx c%0d", cyc), int'(unit_idx), u);
        if (q_sum.size() == 0) begin
          check($sformatf("sum queue c%0d", cyc), 0, 1);
        end else begin
          e_sum = q_sum.pop_front();
          obs_sum[u] = acc_q;
          check($sformatf("unit_sum u%0d", u), acc_q, e_sum);
        end
      end
      check($sformatf("done c%0d", cyc), int'(done), int'(cyc == KN + 2));
      if (disturb && cyc == 3) begin
        tv     = mw[KN-1] ^ 5;
        tvv    = tv;
        w_we   = 1'b1;
        w_addr = AW'(KN - 1);
        w_data = tvv[WW-1:0];
        start  = 1'b1;
        x_in   = x ^ 24'h5A5A5A;
      end
      if (disturb && cyc == 4) begin
        w_we  = 1'b0;
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("gap busy", int'(busy), 0);
    check("gap done", int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [KN-1:0] xt;
    logic [KN-1:0] x2;
    logic [KN-1:0] x3;

    tab[0]  = '{-2, 1'b1, 2, 1'b0};
    tab[1]  = '{ 1, 1'b0, 1, 1'b0};
    tab[2]  = '{ 0, 1'b1, 0, 1'b1};
    tab[3]  = '{-8, 1'b0, 8, 1'b1};
    tab[4]  = '{ 7, 1'b1, 7, 1'b1};
    tab[5]  = '{-1, 1'b1, 1, 1'b0};
    tab[6]  = '{ 2, 1'b0, 2, 1'b0};
    tab[7]  = '{-3, 1'b0, 3, 1'b1};
    tab[8]  = '{-8, 1'b1, 8, 1'b0};
    tab[9]  = '{ 0, 1'b0, 0, 1'b1};
    tab[10] = '{ 7, 1'b0, 7, 1'b0};
    tab[11] = '{-1, 1'b0, 1, 1'b1};
    tab[12] = '{ 1, 1'b1, 1, 1'b1};
    tab[13] = '{-4, 1'b1, 4, 1'b0};
    tab[14] = '{ 3, 1'b0, 3, 1'b0};
    tab[15] = '{-7, 1'b0, 7, 1'b1};

    for (int j = 0; j < KN; j++) mw[j] = 0;

    // Reset with start and a write to index 0 held active.
    rst    = 1'b0;
    start  = 1'b1;
    w_we   = 1'b1;
    w_addr = '0;
    w_data = 4'd5;
    x_in   = '1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst   = 1'b1;
    start = 1'b0;
    w_we  = 1'b0;
    @(posedge clk); #1;
    run_eval('1, 1'b0);

    // All weights +3, all x +1.
    for (int j = 0; j < KN; j++) write_w(j, 3);
    run_eval('1, 1'b0);

    // Sign mix, table driven.
    xt = '0;
    for (int j = 0; j < KN; j++) write_w(j, (j < 16) ? tab[j].w : 0);
    for (int j = 0; j < 16; j++) xt[j] = tab[j].x;
    run_eval(xt, 1'b0);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("table feed %0d", j), obs_feed[j], tab[j].feed);
      check($sformatf("table addflag %0d", j), int'(obs_add[j]), int'(tab[j].add));
    end
    check("table sum u0", obs_sum[0], 12);
    check("table sum u1", obs_sum[1], -13);

    // Interference during busy, then an undisturbed rerun.
    x2 = 24'hC3A596;
    run_eval(x2, 1'b1);
    run_eval(x2, 1'b0);

    // Reset on the 5th FEED cycle.
    start = 1'b1;
    x_in  = x2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 5) rst = 1'b0;
    end
    @(negedge clk);
    check_idle_outputs("midrun");
    rst = 1'b1;
    for (int j = 0; j < KN; j++) mw[j] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post-abort busy %0d", c), int'(busy), 0);
      check($sformatf("post-abort done %0d", c), int'(done), 0);
    end
    for (int j = 0; j < KN; j++) write_w(j, (j % 15) - 7);
    x3 = 24'h3D61E8;
    run_eval(x3, 1'b0);

    // Back-to-back: second start lands on the single idle cycle.
    run_eval(~x3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
